// File: rtl/generic_bus_sram_responder_pkg.sv
// Shared types and constants for the generic-bus SRAM responder.
// Holds the handshake FSM state type, the data word type and the error read pattern.
package generic_bus_resp_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Wait counter holds LATENCY, which is limited to 0..15.
    localparam int CNT_W = 4;

    localparam word_t ERR_RDATA = 32'hBAD0_BAD0;

endpackage

// File: rtl/generic_bus_sram_responder_ram.sv
// Word-organised SRAM array for the generic-bus responder.
// One combinational read port and one byte-masked synchronous write port; contents are never reset.
module generic_bus_resp_ram
    import generic_bus_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          CLK,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    byte_en
);

    word_t mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/generic_bus_sram_responder.sv
// Generic-bus SRAM responder: on-chip word SRAM behind an IDLE/WAIT/RESP handshake with LATENCY wait cycles.
// Define GEN_BUS_RESP_ERR_EN to add an error output flagging accesses outside the SRAM window.
module generic_bus_sram_responder
    import generic_bus_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy
`ifdef GEN_BUS_RESP_ERR_EN
    ,
    output logic        error
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

    resp_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic [AW-1:0]    idx_q;
    word_t            wdata_q;
    logic [3:0]       be_q;
    logic             rd_q;
    logic             wr_q;
    logic             bad_q;

    logic             req;
    word_t            offset;
    logic [AW-1:0]    req_idx;
    logic             addr_bad;
    logic             unused_offset;

    logic [AW-1:0]    ram_raddr;
    word_t            ram_rdata;
    logic             ram_we;

    logic             to_resp;
    logic             resp_rd;
    logic             resp_bad;

    assign req     = ren | wen;
    assign offset  = addr - BASE_ADDR;
    assign req_idx = offset[AW+1:2];
    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef GEN_BUS_RESP_ERR_EN
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    assign addr_bad = (addr < BASE_ADDR) || ({1'b0, addr} >= END_ADDR);
`else
    // Without the error build, the truncated index simply wraps modulo DEPTH_WORDS.
    assign addr_bad = 1'b0;
`endif

    // In IDLE the response can be due next cycle (LATENCY==0), so use the live request.
    always_comb begin
        to_resp   = 1'b0;
        resp_rd   = rd_q;
        resp_bad  = bad_q;
        ram_raddr = idx_q;
        case (state)
            IDLE: begin
                ram_raddr = req_idx;
                resp_rd   = ren;
                resp_bad  = addr_bad;
                to_resp   = req && (LATENCY == 0);
            end
            WAIT: begin
                to_resp = req && (wait_cnt == CNT_W'(1));
            end
            default: begin
                to_resp = 1'b0;
            end
        endcase
    end

    // Commit happens on the edge that ends RESP; a reset in that cycle drops it.
    assign ram_we = (state == RESP) && wr_q && !bad_q && !RST;

    generic_bus_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .CLK     (CLK),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata),
        .we      (ram_we),
        .waddr   (idx_q),
        .wdata   (wdata_q),
        .byte_en (be_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            busy     <= 1'b1;
            rdata    <= '0;
            wait_cnt <= '0;
`ifdef GEN_BUS_RESP_ERR_EN
            error    <= 1'b0;
`endif
        end else begin
            busy <= 1'b1;
`ifdef GEN_BUS_RESP_ERR_EN
            error <= 1'b0;
`endif
            if (to_resp) begin
                busy <= 1'b0;
                if (resp_bad) begin
                    rdata <= ERR_RDATA;
                end else if (resp_rd) begin
                    rdata <= ram_rdata;
                end
`ifdef GEN_BUS_RESP_ERR_EN
                error <= resp_bad;
`endif
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q    <= req_idx;
                        wdata_q  <= wdata;
                        be_q     <= byte_en;
                        rd_q     <= ren;
                        wr_q     <= wen;
                        bad_q    <= addr_bad;
                        wait_cnt <= LAT_LOAD;
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                        if (wait_cnt == CNT_W'(1)) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Bench for generic_bus_sram_responder: a LATENCY=2 and a LATENCY=0 instance checked
// every cycle against a transaction-level model (start cycle, completion cycle, word array).
module tb_generic_bus_sram_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       rst_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       ren_i;
    logic [1:0]       wen_i;
    logic [1:0][3:0]  be_i;
    logic [1:0][31:0] rdata_w;
    logic [1:0]       busy_w;
`ifdef GEN_BUS_RESP_ERR_EN
    logic [1:0]       err_w;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    generic_bus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_l2 (
        .CLK(clk), .RST(rst_i[0]), .addr(addr_i[0]), .wdata(wdata_i[0]), .ren(ren_i[0]),
        .wen(wen_i[0]), .byte_en(be_i[0]), .rdata(rdata_w[0]), .busy(busy_w[0])
`ifdef GEN_BUS_RESP_ERR_EN
        , .error(err_w[0])
`endif
    );

    generic_bus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut_l0 (
        .CLK(clk), .RST(rst_i[1]), .addr(addr_i[1]), .wdata(wdata_i[1]), .ren(ren_i[1]),
        .wen(wen_i[1]), .byte_en(be_i[1]), .rdata(rdata_w[1]), .busy(busy_w[1])
`ifdef GEN_BUS_RESP_ERR_EN
        , .error(err_w[1])
`endif
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int model_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    function automatic logic out_of_window(input logic [31:0] a);
        return (a < BASE) || ({32'b0, a} >= ({32'b0, BASE} + 64'(4 * DEPTH)));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] pre(input int w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding access per instance.
    bit          act [2];
    int          done_c [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_be [2];
    logic        m_r [2];
    logic        m_w [2];
    logic [31:0] mm [2][DEPTH];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic done_now;
                logic oor;
                int   idx;
                done_now = act[d] && (cyc == done_c[d]);
                idx = model_index(m_addr[d]);
                oor = out_of_window(m_addr[d]);
                chk($sformatf("busy d%0d", d), {31'b0, busy_w[d]}, {31'b0, !done_now});
                if (done_now) begin
`ifdef GEN_BUS_RESP_ERR_EN
                    if (oor) chk($sformatf("err rdata d%0d", d), rdata_w[d], 32'hBAD0_BAD0);
                    else if (m_r[d]) chk($sformatf("rdata d%0d", d), rdata_w[d], mm[d][idx]);
                    chk($sformatf("error d%0d", d), {31'b0, err_w[d]}, {31'b0, oor});
`else
                    if (m_r[d]) chk($sformatf("rdata d%0d", d), rdata_w[d], mm[d][idx]);
`endif
                end
`ifdef GEN_BUS_RESP_ERR_EN
                else chk($sformatf("error idle d%0d", d), {31'b0, err_w[d]}, 32'd0);
`endif
                if (rst_i[d]) begin
                    act[d] = 0;
                end else if (act[d]) begin
                    if (done_now) begin
                        act[d] = 0;
`ifdef GEN_BUS_RESP_ERR_EN
                        if (m_w[d] && !oor) mm[d][idx] = merge(mm[d][idx], m_wd[d], m_be[d]);
`else
                        if (m_w[d]) mm[d][idx] = merge(mm[d][idx], m_wd[d], m_be[d]);
`endif
                    end else if (!(ren_i[d] || wen_i[d])) begin
                        act[d] = 0;
                    end
                end else if (ren_i[d] || wen_i[d]) begin
                    act[d]    = 1;
                    done_c[d] = cyc + lat_of(d) + 1;
                    m_addr[d] = addr_i[d];
                    m_wd[d]   = wdata_i[d];
                    m_be[d]   = be_i[d];
                    m_r[d]    = ren_i[d];
                    m_w[d]    = wen_i[d];
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following the response.
    task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic r, input logic w, input logic keep,
                          output logic [31:0] rd, output logic er);
        int lat;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        addr_i[d] = a; wdata_i[d] = wd; be_i[d] = be; ren_i[d] = r; wen_i[d] = w;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy_w[d]) begin
                lat = k;
                rd  = rdata_w[d];
`ifdef GEN_BUS_RESP_ERR_EN
                er  = err_w[d];
`endif
                break;
            end
        end
        chk($sformatf("latency d%0d", d), lat, lat_of(d) + 1);
        @(posedge clk); #1;
        if (!keep) begin
            ren_i[d] = 1'b0;
            wen_i[d] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, rd_a, rd_b;
        logic        er, lowseen;
        logic [3:0]  bv;

        rst_i = 2'b11; addr_i = '0; wdata_i = '0; ren_i = '0; wen_i = '0; be_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 2'b00;
        chk_en = 1;
        @(negedge clk);
        chk("reset busy d0", {31'b0, busy_w[0]}, 32'd1);
        chk("reset busy d1", {31'b0, busy_w[1]}, 32'd1);
        chk("reset rdata d0", rdata_w[0], 32'd0);
        chk("reset rdata d1", rdata_w[1], 32'd0);
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                access(d, BASE + 32'(4 * w), pre(w), 4'hF, 1'b0, 1'b1, 1'b0, rd, er);

        // Full write then read back, LATENCY=2
        access(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 1'b0, rd, er);
        access(0, 32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("readback", rd, 32'hDEAD_BEEF);

        // Byte-lane write
        access(0, 32'h8000_0010, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, 1'b0, rd, er);
        access(0, 32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("byte lanes", rd, 32'hDE22_BE44);

        // LATENCY=0 back-to-back reads with ren held
        addr_i[1] = BASE; ren_i[1] = 1'b1;
        @(negedge clk); bv[0] = busy_w[1];
        @(posedge clk); #1;
        @(negedge clk); bv[1] = busy_w[1]; rd_a = rdata_w[1];
        @(posedge clk); #1; addr_i[1] = BASE + 32'd4;
        @(negedge clk); bv[2] = busy_w[1];
        @(posedge clk); #1;
        @(negedge clk); bv[3] = busy_w[1]; rd_b = rdata_w[1];
        @(posedge clk); #1; ren_i[1] = 1'b0;
        chk("b2b busy pattern", {28'b0, bv}, 32'h5);
        chk("b2b rdata 0", rd_a, 32'hC0DE_0000);
        chk("b2b rdata 1", rd_b, 32'hC0DE_0001);

        // Abort: drop wen in first WAIT cycle
        addr_i[0] = 32'h8000_0020; wdata_i[0] = 32'hFFFF_FFFF; be_i[0] = 4'hF; wen_i[0] = 1'b1;
        @(posedge clk); #1; wen_i[0] = 1'b0;
        lowseen = 1'b0;
        repeat (6) begin @(negedge clk); if (!busy_w[0]) lowseen = 1'b1; end
        chk("abort no pulse", {31'b0, lowseen}, 32'd0);
        @(posedge clk); #1;
        access(0, 32'h8000_0020, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("abort old value", rd, 32'hC0DE_0008);

        // Reset during WAIT of a write
        addr_i[0] = 32'h8000_0024; wdata_i[0] = 32'h0; be_i[0] = 4'hF; wen_i[0] = 1'b1;
        @(posedge clk); #1; rst_i[0] = 1'b1;
        @(posedge clk); #1; rst_i[0] = 1'b0; wen_i[0] = 1'b0;
        @(negedge clk);
        chk("reset mid busy", {31'b0, busy_w[0]}, 32'd1);
        chk("reset mid rdata", rdata_w[0], 32'd0);
        lowseen = 1'b0;
        repeat (5) begin @(negedge clk); if (!busy_w[0]) lowseen = 1'b1; end
        chk("reset no pulse", {31'b0, lowseen}, 32'd0);
        @(posedge clk); #1;
        access(0, 32'h8000_0024, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("reset word kept", rd, 32'hC0DE_0009);

`ifdef GEN_BUS_RESP_ERR_EN
        access(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("oor error", {31'b0, er}, 32'd1);
        chk("oor rdata", rd, 32'hBAD0_BAD0);
        access(0, 32'h8000_1000, 32'h600D_F00D, 4'hF, 1'b0, 1'b1, 1'b0, rd, er);
        chk("oor write error", {31'b0, er}, 32'd1);
        access(0, BASE, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("oor write dropped", rd, 32'hC0DE_0000);
`else
        access(0, 32'h8000_1000, 32'h600D_F00D, 4'hF, 1'b0, 1'b1, 1'b0, rd, er);
        access(0, BASE, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rd, er);
        chk("wrap to word 0", rd, 32'h600D_F00D);
`endif

        // Randomized traffic, checked by the per-cycle model
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                int          kind;
                int          w;
                int          op;
                logic [31:0] a;
                logic        kp;
                kind = $urandom_range(0, 9);
                w    = $urandom_range(0, 15);
                a    = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
                if (kind == 9) a = a + 32'(4 * DEPTH);
                if (kind == 8 && d == 0) begin
                    addr_i[d] = a; wdata_i[d] = $urandom; be_i[d] = 4'hF;
                    wen_i[d] = 1'($urandom_range(0, 1)); ren_i[d] = !wen_i[d];
                    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                    ren_i[d] = 1'b0; wen_i[d] = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    op = $urandom_range(0, 2);
                    kp = ($urandom_range(0, 3) == 0);
                    access(d, a, $urandom, 4'($urandom), op != 1, op != 0, kp, rd, er);
                    if (!kp) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            ren_i[d] = 1'b0; wen_i[d] = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
